w25q128_flash: RTL and testbench



---
 rtl/w25q_pkg.sv | 41 ++++
 rtl/w25q128_flash_spi_pin_sync.sv | 66 ++++++
 rtl/w25q128_flash.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_w25q128_flash.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/w25q_pkg.sv
// w25q_pkg: shared definitions for the w25q128_flash SPI NOR model.
//   - SPI opcodes understood by the model
//   - status register bit positions and status byte helper
//   - protocol FSM state encoding
//   - page and sector geometry
package w25q_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_PP    = 8'h02;
  localparam logic [7:0] OP_SE    = 8'h20;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_JEDEC = 8'h9F;
  localparam logic [7:0] OP_RDID  = 8'hAB;

  localparam logic [7:0] DEVICE_ID = 8'h17;

  localparam int SR_BUSY = 0;
  localparam int SR_WEL  = 1;

  localparam int PAGE_BYTES   = 256;
  localparam int SECTOR_BYTES = 4096;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_CMD      = 3'd1;
  localparam state_t ST_ADDR     = 3'd2;
  localparam state_t ST_DATA_OUT = 3'd3;
  localparam state_t ST_DATA_IN  = 3'd4;
  localparam state_t ST_IGNORE   = 3'd5;

  function automatic logic [7:0] status_byte(input logic wel, input logic busy);
    logic [7:0] s;
    s = 8'h00;
    s[SR_WEL]  = wel;
    s[SR_BUSY] = busy;
    return s;
  endfunction

endpackage

// File: rtl/w25q128_flash_spi_pin_sync.sv
// spi_pin_sync: two-flop synchronisers for the SPI pins plus edge pulses.
//   clk, rst_n          : system clock, synchronous active-low reset
//   cs_n_in, sclk_in,
//   di_in, hold_n_in    : raw asynchronous pins
//   cs_n_s, di_s,
//   hold_n_s            : synchronised levels
//   sclk_rise/sclk_fall : one-clk pulses on synchronised SCLK edges
//   cs_rise/cs_fall     : one-clk pulses on synchronised chip-select edges
module spi_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_n_in,
  input  logic sclk_in,
  input  logic di_in,
  input  logic hold_n_in,
  output logic cs_n_s,
  output logic di_s,
  output logic hold_n_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_rise,
  output logic cs_fall
);

  localparam int NPINS = 4;
  // Bit order: 0 cs_n, 1 sclk, 2 di, 3 hold_n. Idle levels are used at reset
  // so no spurious chip-select edge is seen when reset releases.
  localparam logic [NPINS-1:0] IDLE_LEVEL = 4'b1001;

  logic [NPINS-1:0] pin_in;
  logic [NPINS-1:0] sync_bus;
  logic [NPINS-1:0] prev_bus;

  assign pin_in = {hold_n_in, di_in, sclk_in, cs_n_in};

  genvar gi;
  generate
    for (gi = 0; gi < NPINS; gi++) begin : g_sync
      logic meta_q;
      logic sync_q;
      logic prev_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          meta_q <= IDLE_LEVEL[gi];
          sync_q <= IDLE_LEVEL[gi];
          prev_q <= IDLE_LEVEL[gi];
        end else begin
          meta_q <= pin_in[gi];
          sync_q <= meta_q;
          prev_q <= sync_q;
        end
      end
      assign sync_bus[gi] = sync_q;
      assign prev_bus[gi] = prev_q;
    end
  endgenerate

  assign cs_n_s    = sync_bus[0];
  assign di_s      = sync_bus[2];
  assign hold_n_s  = sync_bus[3];
  assign sclk_rise =  sync_bus[1] & ~prev_bus[1];
  assign sclk_fall = ~sync_bus[1] &  prev_bus[1];
  assign cs_rise   =  sync_bus[0] & ~prev_bus[0];
  assign cs_fall   = ~sync_bus[0] &  prev_bus[0];

endmodule

// File: rtl/w25q128_flash.sv
// w25q128_flash: clock-synchronous W25Q128JV-style SPI NOR flash model.
//   clk, rst_n  : system clock, synchronous active-low reset
//   spi_cs_n    : chip select (active low)
//   spi_clk     : SPI clock, modes 0 and 3, oversampled by clk
//   spi_di      : MOSI, sampled on SCLK rising edge
//   spi_do      : MISO, updated on SCLK falling edge
//   spi_do_oe   : MISO drive enable (cs low and not on hold)
//   wp_n        : write protect, unused
//   hold_n      : hold, freezes shifting while low
// Commands: 03 read, 02 page program, 20 sector erase, 05 status,
// 06/04 write enable/disable, 9F JEDEC id, AB device id.
module w25q128_flash
  import w25q_pkg::*;
#(
  parameter int          MEM_BYTES   = 65536,
  parameter int          PROG_CYCLES = 64,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_cs_n,
  input  logic spi_clk,
  input  logic spi_di,
  output logic spi_do,
  output logic spi_do_oe,
  input  logic wp_n,
  input  logic hold_n
);

  localparam int AW       = $clog2(MEM_BYTES);
  localparam int MAX_BUSY = (PROG_CYCLES > SECTOR_BYTES) ? PROG_CYCLES : SECTOR_BYTES;
  localparam int CNT_W    = $clog2(MAX_BUSY + 1);

  logic cs_n_s, di_s, hold_n_s, sclk_rise, sclk_fall, cs_rise, cs_fall;

  spi_pin_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs_n_in   (spi_cs_n),
    .sclk_in   (spi_clk),
    .di_in     (spi_di),
    .hold_n_in (hold_n),
    .cs_n_s    (cs_n_s),
    .di_s      (di_s),
    .hold_n_s  (hold_n_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_rise   (cs_rise),
    .cs_fall   (cs_fall)
  );

  state_t            state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [22:0]       in_sr_q, in_sr_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [7:0]        out_sr_q, out_sr_d;
  logic [2:0]        out_idx_q, out_idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic              spi_do_q, spi_do_d;
  logic              spi_do_oe_q, spi_do_oe_d;
  logic              wel_q, wel_d;
  logic              busy_q, busy_d;
  logic              erasing_q, erasing_d;
  logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;
  logic [AW-1:0]     erase_addr_q, erase_addr_d;
  logic [5:0]        bits_total_q, bits_total_d;
  logic              armed_q, armed_d;
  logic              prog_any_q, prog_any_d;

  // The array holds inverted data: an all-zero RAM (the configuration-time
  // default of FPGA block RAM) reads back as erased 0xFF.
  logic [7:0]        mem [MEM_BYTES];
  logic [7:0]        ram_rdata_q;
  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;

  logic [23:0]       rx_addr;
  logic [7:0]        rx_byte;
  logic [7:0]        next_byte;
  logic              unused_bits;

  assign rx_addr     = {in_sr_q, di_s};
  assign rx_byte     = rx_addr[7:0];
  assign unused_bits = wp_n ^ (^rx_addr);
  assign ram_addr    = erasing_q ? erase_addr_q : addr_q;

  // Byte to be shifted out when a new output byte starts.
  always_comb begin
    next_byte = 8'h00;
    case (opcode_q)
      OP_RDSR:  next_byte = status_byte(wel_q, busy_q);
      OP_RDID:  next_byte = DEVICE_ID;
      OP_READ:  next_byte = ~ram_rdata_q;
      OP_JEDEC: begin
        case (byte_cnt_q)
          2'd0:    next_byte = JEDEC_ID[23:16];
          2'd1:    next_byte = JEDEC_ID[15:8];
          2'd2:    next_byte = JEDEC_ID[7:0];
          default: next_byte = 8'h00;
        endcase
      end
      default:  next_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    in_sr_d      = in_sr_q;
    opcode_d     = opcode_q;
    addr_d       = addr_q;
    out_sr_d     = out_sr_q;
    out_idx_d    = out_idx_q;
    byte_cnt_d   = byte_cnt_q;
    spi_do_d     = spi_do_q;
    wel_d        = wel_q;
    busy_d       = busy_q;
    erasing_d    = erasing_q;
    busy_cnt_d   = busy_cnt_q;
    erase_addr_d = erase_addr_q;
    bits_total_d = bits_total_q;
    armed_d      = armed_q;
    prog_any_d   = prog_any_q;
    ram_we       = 1'b0;
    ram_wdata    = 8'h00;
    spi_do_oe_d  = ~cs_n_s & hold_n_s;

    // Program/erase timer. Erase writes one byte per cycle while it counts.
    if (busy_q) begin
      if (erasing_q) begin
        ram_we       = 1'b1;
        ram_wdata    = 8'h00;
        erase_addr_d = erase_addr_q + AW'(1);
      end
      busy_cnt_d = busy_cnt_q - CNT_W'(1);
      if (busy_cnt_q == CNT_W'(1)) begin
        busy_d    = 1'b0;
        wel_d     = 1'b0;
        erasing_d = 1'b0;
      end
    end

    // cs rise has priority over a coincident SCLK edge.
    if (cs_rise) begin
      state_d  = ST_IDLE;
      spi_do_d = 1'b0;
      if (armed_q && !busy_q) begin
        if (opcode_q == OP_SE && bits_total_q == 6'd32) begin
          busy_d       = 1'b1;
          erasing_d    = 1'b1;
          busy_cnt_d   = CNT_W'(SECTOR_BYTES);
          erase_addr_d = addr_q & ~AW'(SECTOR_BYTES - 1);
        end else if (opcode_q == OP_PP && prog_any_q) begin
          busy_d     = 1'b1;
          busy_cnt_d = CNT_W'(PROG_CYCLES);
        end
      end
    end else if (cs_fall) begin
      state_d      = ST_CMD;
      bit_cnt_d    = 5'd0;
      bits_total_d = 6'd0;
      armed_d      = 1'b0;
      prog_any_d   = 1'b0;
      out_idx_d    = 3'd0;
      byte_cnt_d   = 2'd0;
      spi_do_d     = 1'b0;
    end else if (!cs_n_s && hold_n_s) begin
      if (sclk_rise) begin
        in_sr_d      = rx_addr[22:0];
        bit_cnt_d    = bit_cnt_q + 5'd1;
        bits_total_d = (bits_total_q == 6'd63) ? bits_total_q : bits_total_q + 6'd1;
        case (state_q)
          ST_CMD: begin
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = 5'd0;
              opcode_d  = rx_byte;
              state_d   = ST_IGNORE;
              if (!busy_q || rx_byte == OP_RDSR) begin
                case (rx_byte)
                  OP_RDSR, OP_JEDEC: state_d = ST_DATA_OUT;
                  OP_READ, OP_RDID:  state_d = ST_ADDR;
                  OP_WREN:           wel_d   = 1'b1;
                  OP_WRDI:           wel_d   = 1'b0;
                  OP_PP, OP_SE: begin
                    if (wel_q) begin
                      state_d = ST_ADDR;
                      armed_d = 1'b1;
                    end
                  end
                  default: ;
                endcase
              end
            end
          end
          ST_ADDR: begin
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = 5'd0;
              addr_d    = rx_addr[AW-1:0];
              case (opcode_q)
                OP_READ, OP_RDID: state_d = ST_DATA_OUT;
                OP_PP:            state_d = ST_DATA_IN;
                default:          state_d = ST_IGNORE;
              endcase
            end
          end
          ST_DATA_IN: begin
            if (bit_cnt_q == 5'd7) begin
              // Stored data is inverted, so AND-programming becomes OR.
              bit_cnt_d  = 5'd0;
              ram_we     = 1'b1;
              ram_wdata  = ram_rdata_q | ~rx_byte;
              addr_d     = {addr_q[AW-1:8], addr_q[7:0] + 8'd1};
              prog_any_d = 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (sclk_fall && state_q == ST_DATA_OUT) begin
        if (out_idx_q == 3'd0) begin
          spi_do_d = next_byte[7];
          out_sr_d = {next_byte[6:0], 1'b0};
        end else begin
          spi_do_d = out_sr_q[7];
          out_sr_d = {out_sr_q[6:0], 1'b0};
        end
        out_idx_d = out_idx_q + 3'd1;
        // Advance on the last bit so the next read word is fetched in time.
        if (out_idx_q == 3'd7) begin
          if (byte_cnt_q != 2'd3) byte_cnt_d = byte_cnt_q + 2'd1;
          if (opcode_q == OP_READ) addr_d = addr_q + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      in_sr_q      <= '0;
      opcode_q     <= '0;
      addr_q       <= '0;
      out_sr_q     <= '0;
      out_idx_q    <= '0;
      byte_cnt_q   <= '0;
      spi_do_q     <= 1'b0;
      spi_do_oe_q  <= 1'b0;
      wel_q        <= 1'b0;
      busy_q       <= 1'b0;
      erasing_q    <= 1'b0;
      busy_cnt_q   <= '0;
      erase_addr_q <= '0;
      bits_total_q <= '0;
      armed_q      <= 1'b0;
      prog_any_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      in_sr_q      <= in_sr_d;
      opcode_q     <= opcode_d;
      addr_q       <= addr_d;
      out_sr_q     <= out_sr_d;
      out_idx_q    <= out_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      spi_do_q     <= spi_do_d;
      spi_do_oe_q  <= spi_do_oe_d;
      wel_q        <= wel_d;
      busy_q       <= busy_d;
      erasing_q    <= erasing_d;
      busy_cnt_q   <= busy_cnt_d;
      erase_addr_q <= erase_addr_d;
      bits_total_q <= bits_total_d;
      armed_q      <= armed_d;
      prog_any_q   <= prog_any_d;
    end
  end

  // Single-port byte RAM with registered read; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata_q <= mem[ram_addr];
  end

  assign spi_do    = spi_do_q;
  assign spi_do_oe = spi_do_oe_q;

endmodule

// File: tb/tb_w25q128_flash.sv
module tb_w25q128_flash;

  localparam int MEM = 65536;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_clk = 1'b0;
  logic spi_di = 1'b0;
  logic hold_n = 1'b1;
  logic wp_n = 1'b1;
  logic spi_do, spi_do_oe;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] model_mem [MEM];
  logic       model_wel = 1'b0;
  logic [7:0] pq [$];

  always #5 clk = ~clk;

  w25q128_flash #(.MEM_BYTES(MEM), .PROG_CYCLES(400), .JEDEC_ID(24'hEF4018)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_cs_n  (spi_cs_n),
    .spi_clk   (spi_clk),
    .spi_di    (spi_di),
    .spi_do    (spi_do),
    .spi_do_oe (spi_do_oe),
    .wp_n      (wp_n),
    .hold_n    (hold_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("chk %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xbit(input logic b, output logic r);
    spi_di = b;
    tick(HALF);
    r = spi_do;
    spi_clk = 1'b1;
    tick(HALF);
    spi_clk = 1'b0;
  endtask

  task automatic xbyte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      xbit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_end();
    tick(HALF);
    spi_cs_n = 1'b1;
    tick(8);
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [7:0] rx;
    xbyte(a[23:16], rx);
    xbyte(a[15:8], rx);
    xbyte(a[7:0], rx);
  endtask

  task automatic cmd1(input logic [7:0] op);
    logic [7:0] rx;
    cs_begin();
    xbyte(op, rx);
    cs_end();
    if (op == 8'h06) model_wel = 1'b1;
    if (op == 8'h04) model_wel = 1'b0;
  endtask

  task automatic read_status(output logic [7:0] st);
    logic [7:0] rx;
    cs_begin();
    xbyte(8'h05, rx);
    xbyte(8'h00, st);
    cs_end();
  endtask

  task automatic check_status(input string tag);
    logic [7:0] st;
    read_status(st);
    check(tag, st, {6'b0, model_wel, 1'b0});
  endtask

  task automatic read_check(input logic [23:0] a, input int n, input string tag);
    logic [7:0] rx;
    int idx;
    cs_begin();
    xbyte(8'h03, rx);
    send_addr(a);
    for (int i = 0; i < n; i++) begin
      xbyte(8'h00, rx);
      idx = (int'(a) + i) % MEM;
      check(tag, rx, model_mem[idx]);
    end
    cs_end();
  endtask

  // Page program of the bytes in pq; the model applies the AND rule with
  // in-page wrap only when write enable was set.
  task automatic do_program(input logic [23:0] a);
    logic [7:0] rx;
    int base, off;
    cs_begin();
    xbyte(8'h02, rx);
    send_addr(a);
    foreach (pq[i]) xbyte(pq[i], rx);
    cs_end();
    if (model_wel && pq.size() > 0) begin
      base = (int'(a) % MEM) / 256 * 256;
      off  = int'(a) % 256;
      foreach (pq[i]) begin
        model_mem[base + off] = model_mem[base + off] & pq[i];
        off = (off + 1) % 256;
      end
      model_wel = 1'b0;
    end
  endtask

  task automatic wait_ready(input string tag, input int min_polls, input int limit);
    logic [7:0] st;
    int polls = 0;
    logic seen_busy = 1'b0;
    logic done = 1'b0;
    st = 8'h00;
    while (!done && polls < limit) begin
      read_status(st);
      polls++;
      if (st[0]) seen_busy = 1'b1;
      else done = 1'b1;
    end
    check({tag, "_busyseen"}, seen_busy, 1'b1);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_minpolls"}, polls >= min_polls, 1'b1);
    check({tag, "_status"}, st, {6'b0, model_wel, 1'b0});
  endtask

  initial begin
    logic [7:0] rx, st;
    logic r;
    logic [23:0] a;
    int n;

    for (int i = 0; i < MEM; i++) model_mem[i] = 8'hFF;

    // Reset
    tick(5);
    check("rst_do", spi_do, 1'b0);
    check("rst_oe", spi_do_oe, 1'b0);
    rst_n = 1'b1;
    tick(3);
    check_status("rst_status");

    // JEDEC id, with output-enable latency at its boundary
    spi_cs_n = 1'b0;
    tick(2);
    check("oe_at2", spi_do_oe, 1'b0);
    tick(1);
    check("oe_at3", spi_do_oe, 1'b1);
    tick(HALF - 3);
    xbyte(8'h9F, rx);
    xbyte(8'h00, rx); check("jedec0", rx, 8'hEF);
    xbyte(8'h00, rx); check("jedec1", rx, 8'h40);
    xbyte(8'h00, rx); check("jedec2", rx, 8'h18);
    xbyte(8'h00, rx); check("jedec3", rx, 8'h00);
    cs_end();
    check("oe_cs_high", spi_do_oe, 1'b0);

    // Device id after three dummy bytes
    cs_begin();
    xbyte(8'hAB, rx);
    send_addr(24'($urandom));
    xbyte(8'h00, rx); check("devid0", rx, 8'h17);
    xbyte(8'h00, rx); check("devid1", rx, 8'h17);
    cs_end();

    // Erased reads, including discarded high address bits
    read_check(24'($urandom), 4, "erased_rd");

    // Program without write enable has no effect
    pq = '{8'hA5};
    do_program(24'h000010);
    read_check(24'h000010, 1, "pp_nowel_rd");
    check_status("pp_nowel_st");

    // WEL set/clear
    cmd1(8'h06); check_status("wren_st");
    cmd1(8'h04); check_status("wrdi_st");
    cmd1(8'h06); check_status("wren_st2");

    // Program across the page boundary (wraps to offset 0 of same page)
    pq = '{8'h12, 8'h34};
    do_program(24'h0000FF);
    wait_ready("pp_wrap", 1, 50);
    read_check(24'h0000FF, 1, "rd_0ff");
    read_check(24'h000000, 1, "rd_000");
    read_check(24'(MEM - 1), 2, "rd_memwrap");

    // Re-program can only clear bits
    cmd1(8'h06);
    pq = '{8'hF0};
    do_program(24'h0000FF);
    wait_ready("pp_reprog", 1, 50);
    read_check(24'h0000FF, 1, "rd_reprog");

    // Random programs checked against the model
    for (int k = 0; k < 4; k++) begin
      a = (k == 0) ? 24'(32'h1000 + $urandom_range(0, 4095)) : 24'($urandom);
      n = $urandom_range(1, 6);
      pq.delete();
      for (int j = 0; j < n; j++) pq.push_back(8'($urandom));
      cmd1(8'h06);
      do_program(a);
      wait_ready("pp_rand", 1, 50);
      read_check(a, n + 1, "rd_rand");
    end

    // Partial byte then cs rise: nothing written, no busy, WEL kept
    cmd1(8'h06);
    cs_begin();
    xbyte(8'h02, rx);
    send_addr(24'h000040);
    for (int i = 0; i < 4; i++) xbit(1'b0, r);
    cs_end();
    check_status("pp_partial_st");
    read_check(24'h000040, 1, "pp_partial_rd");

    // Sector erase with 40 bits clocked is not an erase
    cs_begin();
    xbyte(8'h20, rx);
    send_addr(24'h000000);
    xbyte(8'h00, rx);
    cs_end();
    check_status("se_40bit_st");
    read_check(24'h0000FF, 1, "se_40bit_rd");

    // Real sector erase of sector 0 (WEL still set)
    cs_begin();
    xbyte(8'h20, rx);
    send_addr(24'h000000);
    cs_end();
    read_status(st);
    check("se_busy", st[0], 1'b1);
    cs_begin();
    xbyte(8'h03, rx);
    send_addr(24'h000000);
    xbyte(8'h00, rx); check("rd_in_busy0", rx, 8'h00);
    xbyte(8'h00, rx); check("rd_in_busy1", rx, 8'h00);
    cs_end();
    for (int i = 0; i < 4096; i++) model_mem[i] = 8'hFF;
    model_wel = 1'b0;
    wait_ready("se", 8, 100);
    read_check(24'h000000, 1, "se_rd000");
    read_check(24'h000FFF, 2, "se_rdfff");

    // Unknown opcode drives zeros
    cs_begin();
    xbyte(8'h5A, rx);
    xbyte(8'hFF, rx);
    check("unk_do", rx, 8'h00);
    check("unk_oe", spi_do_oe, 1'b1);
    cs_end();

    // Hold in the middle of a read
    cmd1(8'h06);
    pq = '{8'($urandom), 8'($urandom), 8'($urandom)};
    do_program(24'h002000);
    wait_ready("pp_hold", 1, 50);
    cs_begin();
    xbyte(8'h03, rx);
    send_addr(24'h002000);
    xbyte(8'h00, rx); check("hold_b0", rx, model_mem[16'h2000]);
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) begin
        tick(4);
        hold_n = 1'b0;
        tick(5);
        check("hold_oe", spi_do_oe, 1'b0);
        tick(15);
        hold_n = 1'b1;
        tick(4);
        check("hold_oe_rel", spi_do_oe, 1'b1);
      end
      xbit(1'b0, r);
      rx[i] = r;
    end
    check("hold_b1", rx, model_mem[16'h2001]);
    xbyte(8'h00, rx); check("hold_b2", rx, model_mem[16'h2002]);
    cs_end();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
